tff_down_counter: RTL and testbench
===================================

Name: tff_down_counter

Overview:
- Synchronous down counter built structurally from T flip-flops, which are in turn built from D flip-flops plus a toggle gate.
- Counterpart of the team's up-counting sequential blocks: it counts toward zero rather than away from it.
- Supports parallel load, count enable, zero flag and a terminal-count pulse.
- Used as a delay/timeout timer that feeds other sequential blocks in the same design.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- STOP_AT_ZERO, 0, 1 = hold at zero instead of wrapping.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock edge).
- load  input  1  parallel load strobe.
- load_value  input  WIDTH  value captured on load.
- enable  input  1  count-down enable.
- count  output  WIDTH  current counter value (registered).
- zero  output  1  high when count == 0 (combinational decode of register).
- tc  output  1  terminal-count pulse: enable & (count == 0) & ~load.

Behaviour:
- Reset:
  - reset == 0 at a rising edge forces count = 0 on that edge; the reload register (if present) also clears to 0.
  - zero = 1 after reset; tc = 0 while reset is low (tc gated by reset).
  - No asynchronous path: reset asserted between edges has no effect until the next rising edge.
- Priority per edge: reset > load > enable > hold.
- Load:
  - load == 1 sets count = load_value on the next edge, regardless of enable.
  - tc is suppressed in the load cycle.
- Count:
  - load == 0 and enable == 1 with count != 0 gives count = count - 1 (mod 2^WIDTH).
- Wrap at zero with enable == 1:
  - STOP_AT_ZERO = 0: count becomes 2^WIDTH - 1, unless AUTO_RELOAD_EN is compiled in (see Optional Feature).
  - STOP_AT_ZERO = 1: count holds at 0. tc stays high for every enabled cycle at zero.
- Hold: enable == 0 and load == 0 keeps count unchanged.
- Latency:
  - count changes exactly one edge after the qualifying inputs are sampled.
  - zero and tc are valid in the same cycle as count (no extra register stage).
- Structural rule (T flip-flop toggle conditions, in normal counting):
  - Bit 0 toggles whenever enable is active.
  - Bit i toggles when enable is active and bits 0..i-1 are all 0 (borrow chain).
  - Load and reset are applied through a 2:1 mux in front of each D input, not through the toggle path.
- Glitch-free outputs: count comes directly from flip-flop Q outputs.
- Simultaneous load and enable at count == 0: load wins, count = load_value, tc = 0.
- Reset low together with load/enable: reset wins, count = 0.

Optional Feature:
- Macro: TFF_DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - Adds a WIDTH-bit reload register, written with load_value on every load (cleared by reset).
  - At count == 0 with enable == 1 and load == 0, count = reload register value instead of wrapping.
  - This takes precedence over STOP_AT_ZERO; the counter becomes a periodic timer with period reload+1 and one tc pulse per period.
  - If the reload value is 0, count stays 0 and tc pulses every enabled cycle.
- Undefined: no reload register; wrap/stop behaviour exactly as in Behaviour.

Test Plan:
- Reset: hold reset = 0 for 2 edges with load = 1, load_value = 4'hA -> count = 0, zero = 1, tc = 0; release reset -> count stays 0 until load/enable.
- Load and count: load 4'd5, then enable for 5 edges -> count 5,4,3,2,1,0; zero = 1 only at 0; tc = 1 in the cycle count == 0 with enable high.
- Wrap (STOP_AT_ZERO = 0, macro off): from 0 with enable -> next count = 4'hF; STOP_AT_ZERO = 1 -> count stays 0 for 3 enabled edges, tc high each.
- Priority: count = 0, load = 1, enable = 1, load_value = 4'd9 -> count = 9, tc = 0; reset = 0 with load = 1 mid-count (count = 6) -> count = 0 next edge.
- Hold: count = 7, enable = 0 for 4 edges -> count stays 7, tc = 0.
- Auto-reload (macro on): load 4'd3, enable continuously for 8 edges -> 3,2,1,0,3,2,1,0; tc pulses at each 0; a new load of 4'd1 mid-sequence changes the period to 2.

Source files
------------

// File: rtl/tff_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tff_down_counter
// Brief    : Synchronous down counter built from T flip-flops (D flip-flop
//            plus XOR toggle gate) with a borrow-chain toggle network.
//            Provides parallel load, count enable, zero flag and a
//            terminal-count pulse. Optional compile-time feature:
//            TFF_DOWN_COUNTER_AUTO_RELOAD_EN adds a reload register so the
//            counter runs as a periodic timer instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module tff_down_counter #(
  parameter int WIDTH        = 4,
  parameter int STOP_AT_ZERO = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc
);

  localparam logic c_stop_at_zero = (STOP_AT_ZERO != 0);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] tff_next;
  logic             cnt_en;

  // Zero decode straight off the flop outputs; no extra register stage.
  assign zero = (count_q == '0);

  // Toggling is blocked at zero only when the counter is meant to park there.
  assign cnt_en = enable & ~(zero & c_stop_at_zero);

  // Borrow chain: bit i may toggle only when every lower bit is already 0.
  assign borrow[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
    assign borrow[i] = borrow[i-1] & ~count_q[i-1];
  end

  // T flip-flop toggle gates: next Q = Q xor T.
  for (genvar i = 0; i < WIDTH; i++) begin : g_tff
    assign toggle[i]   = cnt_en & borrow[i];
    assign tff_next[i] = count_q[i] ^ toggle[i];
  end

`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;

  // Reload register follows every load so the period tracks the last value.
  always_comb begin
    reload_d = reload_q;
    if (load) begin
      reload_d = load_value;
    end
  end

  // Reload register storage; cleared with the counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // D-input mux: load overrides the toggle path; at zero the reload value
  // (when present) replaces the natural all-ones wrap.
  always_comb begin
    count_d = tff_next;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
    if (enable && zero) begin
      count_d = reload_q;
    end
`endif
    if (load) begin
      count_d = load_value;
    end
  end

  // Counter flops with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  // Terminal count: enabled cycle at zero, suppressed by load and by reset.
  assign tc = reset & enable & zero & ~load;

endmodule
`default_nettype wire

// File: tb/tb_tff_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tff_down_counter
// Brief    : Self-checking bench for tff_down_counter. Two instances (wrap
//            and stop-at-zero) share stimulus; each is compared against an
//            arithmetic reference model. Honours
//            TFF_DOWN_COUNTER_AUTO_RELOAD_EN in the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tff_down_counter;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;

  logic [W-1:0] count_w, count_s;
  logic         zero_w, zero_s, tc_w, tc_s;

  int checks = 0;
  int failures = 0;

  // Reference state: wrap model, stop model, shared reload register.
  int unsigned m_w = 0;
  int unsigned m_s = 0;
  int unsigned m_rel = 0;

  always #5 clock = ~clock;

  tff_down_counter #(.WIDTH(W), .STOP_AT_ZERO(0)) dut_wrap (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .count(count_w), .zero(zero_w), .tc(tc_w)
  );

  tff_down_counter #(.WIDTH(W), .STOP_AT_ZERO(1)) dut_stop (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .count(count_s), .zero(zero_s), .tc(tc_s)
  );

  // Behavioural next-count rule from the counter's documented behaviour.
  function automatic int unsigned model_next(int unsigned c, bit ld, int unsigned lv,
                                             bit en, bit stop, int unsigned rel);
    if (ld) return lv;
    if (!en) return c;
    if (c != 0) return c - 1;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
    return rel;
`else
    return stop ? 0 : MAXV;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check tc before the edge, advance the
  // model on the edge, then check count and zero just after it.
  task automatic cycle(input bit rst_n, input bit ld, input logic [W-1:0] lv, input bit en);
    bit exp_tc_w, exp_tc_s;
    reset = rst_n;
    load = ld;
    load_value = lv;
    enable = en;
    #1;
    exp_tc_w = rst_n && en && (m_w == 0) && !ld;
    exp_tc_s = rst_n && en && (m_s == 0) && !ld;
    chk("tc_wrap", {31'b0, tc_w}, {31'b0, exp_tc_w});
    chk("tc_stop", {31'b0, tc_s}, {31'b0, exp_tc_s});
    @(posedge clock);
    if (!rst_n) begin
      m_w = 0;
      m_s = 0;
      m_rel = 0;
    end else begin
      m_w = model_next(m_w, ld, lv, en, 1'b0, m_rel);
      m_s = model_next(m_s, ld, lv, en, 1'b1, m_rel);
      if (ld) m_rel = lv;
    end
    #1;
    chk("count_wrap", {28'b0, count_w}, m_w);
    chk("count_stop", {28'b0, count_s}, m_s);
    chk("zero_wrap", {31'b0, zero_w}, {31'b0, (m_w == 0)});
    chk("zero_stop", {31'b0, zero_s}, {31'b0, (m_s == 0)});
  endtask

  initial begin
    // Reset held low with load active: reset must win.
    @(posedge clock);
    #1;
    cycle(1'b0, 1'b1, 4'hA, 1'b1);
    cycle(1'b0, 1'b1, 4'hA, 1'b1);
    chk("reset_count_const", {28'b0, count_w}, 32'h0);
    // Released, idle: stays at zero.
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);

    // Load 5 and count down through zero, then past it.
    cycle(1'b1, 1'b1, 4'd5, 1'b0);
    chk("load5_const", {28'b0, count_w}, 32'd5);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);

    // Load and enable together at zero: load wins, tc suppressed.
    cycle(1'b1, 1'b1, 4'd0, 1'b0);
    cycle(1'b1, 1'b1, 4'd9, 1'b1);
    chk("prio_load_const", {28'b0, count_s}, 32'd9);

    // Reset mid-count with load active.
    cycle(1'b1, 1'b1, 4'd6, 1'b0);
    cycle(1'b0, 1'b1, 4'd6, 1'b1);

    // Hold at 7 for four edges.
    cycle(1'b1, 1'b1, 4'd7, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'h3, 1'b0);
    chk("hold_const", {28'b0, count_w}, 32'd7);

    // Periodic reload sequence, then a new period mid-run.
    cycle(1'b1, 1'b1, 4'd3, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);
    cycle(1'b1, 1'b1, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) >= 4),
            ($urandom_range(0, 99) < 15),
            4'($urandom_range(0, MAXV)),
            ($urandom_range(0, 99) < 75));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
